vga_multi_box_engine: RTL

//  Parametrised bouncing-box sprite engine: NUM_BOXES independent squares move and bounce
//   off the screen edges, one update per frame.

---
 rtl/vga_box_pkg.sv | 16 +
 rtl/box_axis_step.sv | 24 ++
 rtl/vga_multi_box_engine.sv | 103 ++++++++++
 3 files changed

// File: rtl/vga_box_pkg.sv
// vga_box_pkg: shared constants, colour table, box state and FSM state types for the box engine
package vga_box_pkg;
   localparam int RGB_W = 6;
   localparam logic [RGB_W-1:0] BOX_COLOUR [0:7] = '{
      6'b111111, 6'b110000, 6'b001100, 6'b000011,
      6'b111100, 6'b001111, 6'b110011, 6'b101010
   };
   localparam logic [RGB_W-1:0] BORDER_COLOUR = 6'b000011;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       dx;
      logic       dy;
   } box_state;
   typedef enum logic {ST_IDLE, ST_UPDATE} fsm_state_t;
endpackage

// File: rtl/box_axis_step.sv
// box_axis_step: one-axis move with edge bounce; speed 0 freezes position and direction
module box_axis_step #(
   parameter int SIZE = 32,
   parameter int RES  = 640,
   parameter int SW   = 4
) (
   input  logic [9:0]    pos,
   input  logic          dir,
   input  logic [SW-1:0] s,
   output logic [9:0]    pos_n,
   output logic          dir_n
);
   logic [10:0] ext, sx;
   logic        hi, lo;
   assign ext = {1'b0, pos};
   assign sx  = 11'(s);
   assign hi  = ext + 11'(SIZE) + sx >= 11'(RES - 1);
   assign lo  = ext < sx;
   always_comb begin
      pos_n = (s == '0) ? pos : !dir ? (hi ? 10'(RES - 1 - SIZE) : 10'(ext + sx))
                                     : (lo ? 10'd0 : 10'(ext - sx));
      dir_n = (s == '0) ? dir : !dir ? hi : !lo;
   end
endmodule

// File: rtl/vga_multi_box_engine.sv
// vga_multi_box_engine: bouncing box sprites updated once per frame; VGA_BOX_BORDER_EN adds a blue screen border
module vga_multi_box_engine
   import vga_box_pkg::*;
#(
   parameter int NUM_BOXES = 4,
   parameter int BOX_SIZE  = 32,
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int SPEED_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vsync,
   input  logic               pause,
   input  logic [SPEED_W-1:0] speed,
   input  logic [9:0]         pix_x,
   input  logic [9:0]         pix_y,
   input  logic               video_active,
   output logic [RGB_W-1:0]   rgb,
   output logic               busy,
   output logic               overrun
);
   localparam int IW = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_BOXES - 1);

   fsm_state_t state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic vsync_q, tick, upd, ovr_set;
   box_state boxes [NUM_BOXES];
   box_state cur;
   logic [9:0] nx, ny;
   logic ndx, ndy;
   logic [RGB_W-1:0] col, bg;

   assign tick = vsync & ~vsync_q;
   assign busy = state == ST_UPDATE;
   assign cur  = boxes[idx];

   always_comb begin
      state_n = state;
      idx_n   = idx;
      upd     = 1'b0;
      ovr_set = 1'b0;
      if (state == ST_IDLE) begin
         state_n = (tick && !pause) ? ST_UPDATE : ST_IDLE;
         idx_n   = '0;
      end else begin
         upd     = 1'b1;
         ovr_set = tick;
         state_n = (idx == LAST) ? ST_IDLE : ST_UPDATE;
         idx_n   = (idx == LAST) ? idx : idx + 1'b1;
      end
   end

   // Both axis steppers are shared by all boxes, one box per clock
   box_axis_step #(.SIZE(BOX_SIZE), .RES(H_RES), .SW(SPEED_W)) u_step_x (
      .pos(cur.x), .dir(cur.dx), .s(speed), .pos_n(nx), .dir_n(ndx)
   );
   box_axis_step #(.SIZE(BOX_SIZE), .RES(V_RES), .SW(SPEED_W)) u_step_y (
      .pos(cur.y), .dir(cur.dy), .s(speed), .pos_n(ny), .dir_n(ndy)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         idx     <= '0;
         vsync_q <= 1'b0;
         overrun <= 1'b0;
         for (int i = 0; i < NUM_BOXES; i++) begin
            boxes[i].x  <= 10'(i * (BOX_SIZE + 8));
            boxes[i].y  <= 10'(i * 16);
            boxes[i].dx <= 1'(i);
            boxes[i].dy <= 1'(i >> 1);
         end
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         vsync_q <= vsync;
         overrun <= overrun | ovr_set;
         if (upd) boxes[idx] <= '{x: nx, y: ny, dx: ndx, dy: ndy};
      end
   end

`ifdef VGA_BOX_BORDER_EN
   assign bg = (pix_x < 10'd2 || pix_x > 10'(H_RES - 3) || pix_y < 10'd2 || pix_y > 10'(V_RES - 3))
             ? BORDER_COLOUR : '0;
`else
   assign bg = '0;
`endif

   // Descending scan so the lowest-index hit is the last assignment and wins
   always_comb begin
      col = bg;
      for (int i = NUM_BOXES - 1; i >= 0; i--)
         if ({1'b0, pix_x} >= {1'b0, boxes[i].x} && {1'b0, pix_x} < {1'b0, boxes[i].x} + 11'(BOX_SIZE) &&
             {1'b0, pix_y} >= {1'b0, boxes[i].y} && {1'b0, pix_y} < {1'b0, boxes[i].y} + 11'(BOX_SIZE))
            col = BOX_COLOUR[i];
   end

   always_ff @(posedge clk) begin
      rgb <= reset ? '0 : (video_active ? col : '0);
   end
endmodule
